iwrr_arbiter_core: RTL and testbench

Sequential interleaved weighted round-robin (IWRR) arbiter. It holds per-requester credit counters that are loaded from programmable weights at each round start. Grants are issued one at a time, rotating across requesters, through a valid/ready grant handshake. It detects round completion internally and emits a pulse plus a round counter, and it sits between request sources and a shared resource as the drop-in successor to the purely combinational round-completion detection logic.

---
 rtl/iwrr_arbiter_core_pkg.sv | 26 ++
 rtl/iwrr_arbiter_core_arb_rr_picker.sv | 47 ++++
 rtl/iwrr_arbiter_core.sv | 208 ++++++++++++++++++++
 tb/tb_iwrr_arbiter_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/iwrr_arbiter_core_pkg.sv
// -----------------------------------------------------------------------------
// iwrr_arbiter_core_pkg
// Shared definitions for the interleaved weighted round-robin arbiter:
// FSM state encoding and a small helper for sizing the rotation pointer.
// -----------------------------------------------------------------------------
package iwrr_arbiter_core_pkg;

  localparam int STATE_W = 2;

  // INIT  : first credit load after reset (no round pulse)
  // ARB   : waiting for an eligible requester
  // GRANT : grant offered, waiting for the consumer handshake
  // LOAD  : round finished, credits reload, round pulse
  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iwrr_arbiter_core_arb_rr_picker.sv
// -----------------------------------------------------------------------------
// arb_rr_picker
// Combinational circular first-one finder. Starting at ptr_i and moving
// upward (wrapping past P_N-1 to 0), returns the first set bit of elig_i as a
// one-hot vector.
//
// Ports:
//   elig_i  [P_N-1:0]      eligible requesters
//   ptr_i   [P_PTR_W-1:0]  index where the search starts (must be < P_N)
//   pick_o  [P_N-1:0]      one-hot winner, zero when nothing is eligible
//   any_o                  at least one requester is eligible
// -----------------------------------------------------------------------------
module arb_rr_picker #(
  parameter int P_N     = 4,
  parameter int P_PTR_W = 2
) (
  input  logic [P_N-1:0]     elig_i,
  input  logic [P_PTR_W-1:0] ptr_i,
  output logic [P_N-1:0]     pick_o,
  output logic               any_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap test.
  localparam int IW = P_PTR_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < P_N; k++) begin
      idx = {1'b0, ptr_i} + IW'(k);
      if (idx >= IW'(P_N)) begin
        idx = idx - IW'(P_N);
      end
      if (!found && elig_i[idx[P_PTR_W-1:0]]) begin
        pick_o[idx[P_PTR_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

  assign any_o = |elig_i;

endmodule

// File: rtl/iwrr_arbiter_core.sv
// -----------------------------------------------------------------------------
// iwrr_arbiter_core
// Sequential interleaved weighted round-robin arbiter. Each requester owns a
// credit counter reloaded from its programmable weight at every round start.
// One grant at a time is offered through a valid/ready handshake, rotating
// across requesters; each accepted grant consumes one credit. When all credits
// are spent (or nobody requesting has credit left while some requester with a
// non-zero weight is still asking) the round ends: credits reload, a one-cycle
// pulse is emitted and the completed-round counter advances.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   req_i          level request per requester (bit n = requester n)
//   req_weight_i   packed weights, requester 0 in the leftmost field
//   grant_o        registered one-hot grant, meaningful when grant_valid_o=1
//   grant_valid_o  grant offered
//   grant_ready_i  consumer accepts the offered grant
//   round_comp_o   one-cycle pulse while credits reload at round end
//   round_cnt_o    completed rounds, wraps modulo 2^P_ROUND_CNT_W
// -----------------------------------------------------------------------------
module iwrr_arbiter_core
  import iwrr_arbiter_core_pkg::*;
#(
  parameter int P_REQUESTER_NUM = 4,
  parameter int P_WEIGHT_W      = 3,
  parameter int P_ROUND_CNT_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_REQUESTER_NUM-1:0]            req_i,
  input  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i,
  output logic [P_REQUESTER_NUM-1:0]            grant_o,
  output logic                                  grant_valid_o,
  input  logic                                  grant_ready_i,
  output logic                                  round_comp_o,
  output logic [P_ROUND_CNT_W-1:0]              round_cnt_o
);

  localparam int N     = P_REQUESTER_NUM;
  localparam int W     = P_WEIGHT_W;
  localparam int PTR_W = ptr_width(P_REQUESTER_NUM);

  // State registers and their next-state values
  state_e                   state_q, state_d;
  logic [N-1:0][W-1:0]      credit_q, credit_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [N-1:0]             grant_q, grant_d;
  logic                     grant_valid_q, grant_valid_d;
  logic                     round_comp_q, round_comp_d;
  logic [P_ROUND_CNT_W-1:0] round_cnt_q, round_cnt_d;

  // Unpacked views and derived vectors
  logic [N-1:0][W-1:0] weight;
  logic [N-1:0][W-1:0] credit_hs;
  logic [N-1:0]        weight_nz;
  logic [N-1:0]        credit_nz;
  logic [N-1:0]        credit_hs_nz;
  logic [N-1:0]        elig_arb;
  logic [N-1:0]        elig_hs;
  logic [N-1:0]        pick_arb;
  logic [N-1:0]        pick_hs;
  logic                any_arb;
  logic                any_hs;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    ptr_hs;
  logic                handshake;
  logic                early_reload;

  // The weight bus is ascending, so n*W is the MSB of requester n's field;
  // assigning the ascending slice into a descending vector keeps that order.
  for (genvar n = 0; n < N; n++) begin : g_unpack
    assign weight[n]       = req_weight_i[n*W +: W];
    assign weight_nz[n]    = |weight[n];
    assign credit_nz[n]    = |credit_q[n];
    assign credit_hs_nz[n] = |credit_hs[n];
  end

  assign handshake    = grant_valid_q & grant_ready_i;
  assign elig_arb     = req_i & credit_nz;
  assign elig_hs      = req_i & credit_hs_nz;
  // A requester is still asking and would get credit from a reload, but no
  // one asking has credit now: finish the round early instead of stalling.
  assign early_reload = |(req_i & weight_nz);

  // Credits and pointer as they will be after the current grant is accepted.
  always_comb begin
    credit_hs = credit_q;
    grant_idx = '0;
    for (int n = 0; n < N; n++) begin
      if (grant_q[n]) begin
        credit_hs[n] = credit_q[n] - W'(1);
        grant_idx    = PTR_W'(n);
      end
    end
    if (grant_idx == PTR_W'(N - 1)) begin
      ptr_hs = '0;
    end else begin
      ptr_hs = grant_idx + PTR_W'(1);
    end
  end

  arb_rr_picker #(
    .P_N     (N),
    .P_PTR_W (PTR_W)
  ) u_pick_arb (
    .elig_i (elig_arb),
    .ptr_i  (ptr_q),
    .pick_o (pick_arb),
    .any_o  (any_arb)
  );

  // Second picker looks ahead with post-handshake credits and pointer so a
  // new grant can follow an accepted one without an idle cycle.
  arb_rr_picker #(
    .P_N     (N),
    .P_PTR_W (PTR_W)
  ) u_pick_hs (
    .elig_i (elig_hs),
    .ptr_i  (ptr_hs),
    .pick_o (pick_hs),
    .any_o  (any_hs)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    round_comp_d  = 1'b0;
    round_cnt_d   = round_cnt_q;

    unique case (state_q)
      ST_INIT: begin
        credit_d = weight;
        state_d  = ST_ARB;
      end

      ST_ARB: begin
        if (any_arb) begin
          grant_d       = pick_arb;
          grant_valid_d = 1'b1;
          state_d       = ST_GRANT;
        end else if (early_reload) begin
          round_comp_d = 1'b1;
          state_d      = ST_LOAD;
        end
      end

      ST_GRANT: begin
        // Grant is held regardless of req_i until the consumer accepts it.
        if (handshake) begin
          credit_d = credit_hs;
          ptr_d    = ptr_hs;
          if (~|credit_hs_nz) begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            round_comp_d  = 1'b1;
            state_d       = ST_LOAD;
          end else if (any_hs) begin
            grant_d = pick_hs;
          end else begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            state_d       = ST_ARB;
          end
        end
      end

      ST_LOAD: begin
        credit_d    = weight;
        round_cnt_d = round_cnt_q + P_ROUND_CNT_W'(1);
        state_d     = ST_ARB;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      credit_q      <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      round_comp_q  <= 1'b0;
      round_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      round_comp_q  <= round_comp_d;
      round_cnt_q   <= round_cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign round_comp_o  = round_comp_q;
  assign round_cnt_o   = round_cnt_q;

endmodule

// File: tb/tb_iwrr_arbiter_core.sv
module tb_iwrr_arbiter_core;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [0:11] wts;
  logic        ready;
  logic [3:0]  grant;
  logic        gv;
  logic        comp;
  logic [7:0]  cnt;

  logic [3:0]  req2;
  logic [0:11] wts2;
  logic        ready2;
  logic [3:0]  grant2;
  logic        gv2;
  logic        comp2;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  iwrr_arbiter_core #(
    .P_REQUESTER_NUM (4),
    .P_WEIGHT_W      (3),
    .P_ROUND_CNT_W   (8)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .req_weight_i  (wts),
    .grant_o       (grant),
    .grant_valid_o (gv),
    .grant_ready_i (ready),
    .round_comp_o  (comp),
    .round_cnt_o   (cnt)
  );

  iwrr_arbiter_core #(
    .P_REQUESTER_NUM (4),
    .P_WEIGHT_W      (3),
    .P_ROUND_CNT_W   (2)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req2),
    .req_weight_i  (wts2),
    .grant_o       (grant2),
    .grant_valid_o (gv2),
    .grant_ready_i (ready2),
    .round_comp_o  (comp2),
    .round_cnt_o   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] seq1 [6];
    logic [3:0] seq2 [4];
    logic [1:0] cnt_seq [5];

    seq1    = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100, 4'b0100};
    seq2    = '{4'b0100, 4'b0001, 4'b0100, 4'b0100};
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst    = 1'b1;
    req    = 4'b0000;
    ready  = 1'b0;
    wts    = {3'd2, 3'd1, 3'd3, 3'd0};
    req2   = 4'b0000;
    ready2 = 1'b1;
    wts2   = {3'd1, 3'd0, 3'd0, 3'd0};

    // Reset state
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_gv", gv, 0);
    chk("rst_comp", comp, 0);
    chk("rst_cnt", cnt, 0);

    // Weighted rotation {2,1,3,0}, all requesting, always ready
    rst   = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;
    step();  // INIT -> ARB
    chk("init_gv", gv, 0);
    chk("init_comp", comp, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("r1_grant%0d", i), grant, seq1[i]);
      chk($sformatf("r1_gv%0d", i), gv, 1);
      chk($sformatf("r1_comp%0d", i), comp, 0);
    end
    step();  // LOAD
    chk("r1_load_gv", gv, 0);
    chk("r1_load_comp", comp, 1);
    chk("r1_load_cnt", cnt, 0);
    step();  // ARB
    chk("r1_arb_comp", comp, 0);
    chk("r1_arb_cnt", cnt, 1);
    chk("r1_arb_gv", gv, 0);
    step();  // first grant of round 2
    chk("r2_first_grant", grant, 4'b0001);
    chk("r2_first_gv", gv, 1);

    // Back-pressure: ready low for 5 cycles, grant must hold
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall_grant%0d", i), grant, 4'b0001);
      chk($sformatf("stall_gv%0d", i), gv, 1);
    end
    ready = 1'b1;
    step();
    chk("r2_grant1", grant, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("r2_grant%0d", i + 2), grant, seq2[i]);
      chk($sformatf("r2_gv%0d", i + 2), gv, 1);
    end
    step();
    chk("r2_load_comp", comp, 1);
    chk("r2_load_gv", gv, 0);
    step();
    chk("r2_arb_cnt", cnt, 2);
    chk("r2_arb_comp", comp, 0);

    // Early reload: only requester 0 asks; new weights take effect at reload
    wts = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b0001;
    step();
    chk("er_g_a", grant, 4'b0001);
    chk("er_gv_a", gv, 1);
    step();  // back-to-back to 0 (its old credit was 2)
    chk("er_g_b", grant, 4'b0001);
    chk("er_gv_b", gv, 1);
    step();
    chk("er_gv_c", gv, 0);
    chk("er_comp_c", comp, 0);
    step();
    chk("er_comp_load1", comp, 1);
    step();
    chk("er_cnt3", cnt, 3);
    chk("er_comp_off1", comp, 0);
    step();
    chk("er_g_d", grant, 4'b0001);
    chk("er_gv_d", gv, 1);
    step();
    chk("er_gv_e", gv, 0);
    step();
    chk("er_comp_load2", comp, 1);
    chk("er_cnt_load2", cnt, 3);
    step();
    chk("er_cnt4", cnt, 4);
    step();
    chk("er_g_f", grant, 4'b0001);
    chk("er_gv_f", gv, 1);

    // Zero weights: drain the {1,1,1,1} round, then nothing more happens
    wts = {3'd0, 3'd0, 3'd0, 3'd0};
    req = 4'b1111;
    step();
    chk("zw_g1", grant, 4'b0010);
    step();
    chk("zw_g2", grant, 4'b0100);
    step();
    chk("zw_g3", grant, 4'b1000);
    step();
    chk("zw_load_comp", comp, 1);
    step();
    chk("zw_cnt5", cnt, 5);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("zw_idle_gv%0d", i), gv, 0);
      chk($sformatf("zw_idle_comp%0d", i), comp, 0);
    end
    chk("zw_idle_cnt", cnt, 5);
    wts = {3'd1, 3'd0, 3'd0, 3'd0};
    step();
    chk("zw_reload_comp", comp, 1);
    step();
    chk("zw_reload_cnt", cnt, 6);
    step();
    chk("zw_grant0", grant, 4'b0001);
    chk("zw_grant0_gv", gv, 1);

    // Asynchronous reset while a grant is offered
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gv", gv, 0);
    chk("arst_grant", grant, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_comp", comp, 0);
    step();
    rst = 1'b0;
    step();  // INIT -> ARB
    chk("rinit_comp", comp, 0);
    chk("rinit_cnt", cnt, 0);
    chk("rinit_gv", gv, 0);
    step();
    chk("rinit_grant", grant, 4'b0001);
    chk("rinit_gv1", gv, 1);
    step();
    chk("rinit_load_comp", comp, 1);
    chk("rinit_load_cnt", cnt, 0);

    // 2-bit round counter wraps
    req2 = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      step();
      step();
      step();
      chk($sformatf("wrap_cnt%0d", r), cnt2, cnt_seq[r]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
